tuner_hop_ctrl: RTL and testbench
=================================

// Module: tuner_hop_ctrl
// PURPOSE
//  Frequency-hop / sweep scheduler for the complex tuner. Steps through a programmable hop
//  table, drives the tuner NCO tuning word and direction, and blanks the mixer output while
//  the NCO/mixer pipeline settles after each retune. Sits between the control register
//  file (table writes, start/stop) and the tuner's lo_freq/lo_dir inputs.
// PARAMETERS
//  FSZ     31  NCO tuning word width (matches the tuner)
//  AW      3   hop table address width; table depth = 2**AW entries
//  DWSZ    24  dwell counter width (cycles per hop)
//  SETTLE  4   mute cycles after each retune (NCO + LO reg + mixer latency); must be >= 1
// PORTS
//  clk        in   1     system clock, all logic on rising edge
//  reset_n    in   1     synchronous, active-low reset
//  start      in   1     1-cycle pulse: begin schedule at entry 0 (ignored while busy)
//  stop       in   1     1-cycle pulse: finish current dwell, then go idle (ignored when idle)
//  loop_en    in   1     1 = wrap from last entry to entry 0; 0 = single pass
//  last_idx   in   AW    index of final table entry used (sampled at start)
//  tbl_we     in   1     table write strobe
//  tbl_addr   in   AW    table write address
//  tbl_freq   in   FSZ   entry tuning word
//  tbl_dir    in   1     entry LO direction
//  tbl_dwell  in   DWSZ  entry dwell length in cycles (0 treated as 1)
//  lo_freq    out  FSZ   tuning word to tuner (registered)
//  lo_dir     out  1     direction to tuner (registered)
//  mute       out  1     1 = downstream must discard tuner output
//  hop_strobe out  1     1-cycle pulse in the cycle lo_freq/lo_dir change
//  hop_idx    out  AW    table index currently applied
//  busy       out  1     1 whenever state != IDLE
// BEHAVIOUR
//  - Reset (reset_n=0 at an edge, any state): state IDLE; lo_freq=0, lo_dir=0, mute=0,
//    hop_strobe=0, hop_idx=0, busy=0, stop_pending=0. Table contents NOT cleared.
//  - States: IDLE -> FETCH -> APPLY -> SETTLE -> DWELL -> (FETCH | IDLE).
//  - IDLE: outputs hold last applied freq/dir. start=1 -> FETCH, idx=0, latch last_idx.
//  - FETCH (1 cyc): registered table read of entry idx into hop latch (freq, dir, dwell).
//  - APPLY (1 cyc): at its closing edge lo_freq/lo_dir/hop_idx load from latch,
//    hop_strobe=1, mute=1, settle counter = SETTLE-1; -> SETTLE.
//  - SETTLE: mute=1; counter decrements; at 0 -> DWELL, dwell counter = max(dwell,1)-1.
//    mute high exactly SETTLE cycles, first one coincident with hop_strobe.
//  - DWELL: mute=0; counter decrements; at 0: if stop_pending or (idx==last && !loop_en)
//    -> IDLE (clear stop_pending); else idx = (idx==last)?0:idx+1 -> FETCH.
//  - Latency: start sampled at edge E -> hop_strobe/new lo_freq visible after edge E+2.
//    Hop period = 2 + SETTLE + max(dwell,1) cycles; mute low during FETCH/APPLY (old freq valid).
//  - stop: sets stop_pending in any non-IDLE state; never truncates SETTLE or DWELL.
//    start and stop in the same cycle from IDLE: start wins, stop ignored.
//  - start while busy: ignored (no restart). loop_en sampled live at each DWELL end.
//  - Table writes accepted in any state. Write to the entry in use affects only its next
//    fetch. Write and FETCH to same address in same cycle: FETCH returns old data.
//  - Counters never wrap: dwell/settle counters stop at 0; idx compares against latched last_idx.
// CONFIGURATION
//  TUNER_HOP_IRQ_EN defined: adds outputs done_irq (1) and inputs irq_clr (1); done_irq is
//    a sticky flag set on the IDLE transition at end of a single pass or after stop, cleared
//    by irq_clr (set wins if same cycle), reset to 0.
//  Not defined: ports absent, no flag logic; all other behaviour identical.
// TESTING
//  1 reset: drive reset_n=0 mid-DWELL -> next cycle busy=0, mute=0, lo_freq=0, table intact.
//  2 single pass: entries {0x1000,dir0,dwell 10},{0x2000,dir1,dwell 5}, last_idx=1, loop_en=0,
//    SETTLE=4 -> strobes 16 cycles apart (2+4+10), lo_freq 0x1000 then 0x2000, busy drops
//    after 2+4+5 more cycles; lo_freq stays 0x2000.
//  3 loop + stop: loop_en=1, last_idx=1, pulse stop during entry-0 SETTLE -> entry 0 dwell
//    completes in full, no strobe for entry 1, then IDLE.
//  4 dwell 0 and wrap: entry dwell=0 -> exactly 1 unmuted DWELL cycle; loop_en=1, last_idx=2
//    -> hop_idx sequence 0,1,2,0,1.
//  5 table collision: write entry 1 freq 0x3333 in the FETCH cycle of entry 1 -> applies old
//    freq; next loop applies 0x3333.
//  6 TUNER_HOP_IRQ_EN: single pass end -> done_irq=1 until irq_clr; irq_clr with set same
//    cycle -> stays 1; start while busy -> no restart, hop_idx unchanged.

Source files
------------

// File: rtl/tuner_hop_ctrl.sv
// rtl/tuner_hop_ctrl.sv - frequency-hop / sweep scheduler driving the tuner NCO word and direction
//
// Steps through a programmable hop table. For each entry it fetches the word,
// applies it to lo_freq/lo_dir, mutes the mixer output for SETTLE cycles, then
// dwells for max(dwell,1) unmuted cycles before moving on.
//
// Optional feature macro: TUNER_HOP_IRQ_EN adds a sticky done_irq flag with irq_clr.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, stop           1-cycle control pulses
//   loop_en, last_idx     wrap enable (sampled live), final entry index (latched at start)
//   tbl_we/addr/freq/dir/dwell   hop table write port
//   lo_freq, lo_dir       registered tuning word / direction to the tuner
//   mute                  downstream must discard tuner output
//   hop_strobe            pulse in the cycle lo_freq/lo_dir change
//   hop_idx               table index currently applied
//   busy                  schedule running
//   done_irq, irq_clr     (TUNER_HOP_IRQ_EN only) end-of-schedule flag and its clear
module tuner_hop_ctrl #(
  parameter int FSZ    = 31,
  parameter int AW     = 3,
  parameter int DWSZ   = 24,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            stop,
  input  logic            loop_en,
  input  logic [AW-1:0]   last_idx,
  input  logic            tbl_we,
  input  logic [AW-1:0]   tbl_addr,
  input  logic [FSZ-1:0]  tbl_freq,
  input  logic            tbl_dir,
  input  logic [DWSZ-1:0] tbl_dwell,
  output logic [FSZ-1:0]  lo_freq,
  output logic            lo_dir,
  output logic            mute,
  output logic            hop_strobe,
  output logic [AW-1:0]   hop_idx,
  output logic            busy
`ifdef TUNER_HOP_IRQ_EN
  ,
  output logic            done_irq,
  input  logic            irq_clr
`endif
);

  localparam int DEPTH = 1 << AW;
  localparam logic [DWSZ-1:0] SETTLE_LOAD = DWSZ'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_APPLY,
    S_SETTLE,
    S_DWELL
  } state_t;

  state_t state, state_nx;

  logic [FSZ-1:0]  mem_freq  [DEPTH];
  logic            mem_dir   [DEPTH];
  logic [DWSZ-1:0] mem_dwell [DEPTH];

  logic [AW-1:0]   idx;
  logic [AW-1:0]   last_q;
  logic            stop_pending;
  logic [FSZ-1:0]  hop_freq;
  logic            hop_dir;
  logic [DWSZ-1:0] hop_dwell;
  logic [DWSZ-1:0] cnt;

  logic cnt_zero;
  logic dwell_end;
  logic pass_end;

  assign cnt_zero  = (cnt == '0);
  assign dwell_end = (state == S_DWELL) && cnt_zero;
  // Schedule finishes on a pending stop or at the last entry of a single pass.
  assign pass_end  = stop_pending || ((idx == last_q) && !loop_en);

  assign mute = (state == S_SETTLE);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_FETCH;
      S_FETCH:  state_nx = S_APPLY;
      S_APPLY:  state_nx = S_SETTLE;
      S_SETTLE: if (cnt_zero) state_nx = S_DWELL;
      S_DWELL:  if (cnt_zero) state_nx = pass_end ? S_IDLE : S_FETCH;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Table is deliberately not reset. A write and a fetch of the same entry in
  // one cycle return the old contents because the read is registered.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      mem_freq[tbl_addr]  <= tbl_freq;
      mem_dir[tbl_addr]   <= tbl_dir;
      mem_dwell[tbl_addr] <= tbl_dwell;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx          <= '0;
      last_q       <= '0;
      hop_freq     <= '0;
      hop_dir      <= 1'b0;
      hop_dwell    <= '0;
      cnt          <= '0;
      lo_freq      <= '0;
      lo_dir       <= 1'b0;
      hop_idx      <= '0;
      hop_strobe   <= 1'b0;
    end else begin
      hop_strobe <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            idx    <= '0;
            last_q <= last_idx;
          end
        end
        S_FETCH: begin
          hop_freq  <= mem_freq[idx];
          hop_dir   <= mem_dir[idx];
          hop_dwell <= mem_dwell[idx];
        end
        S_APPLY: begin
          lo_freq    <= hop_freq;
          lo_dir     <= hop_dir;
          hop_idx    <= idx;
          hop_strobe <= 1'b1;
          cnt        <= SETTLE_LOAD;
        end
        S_SETTLE: begin
          // Zero dwell is stretched to one cycle.
          if (cnt_zero) cnt <= (hop_dwell == '0) ? '0 : hop_dwell - 1'b1;
          else          cnt <= cnt - 1'b1;
        end
        S_DWELL: begin
          if (!cnt_zero)     cnt <= cnt - 1'b1;
          else if (!pass_end) idx <= (idx == last_q) ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clearing on the return to IDLE takes priority so a late stop cannot leak
  // into the next schedule.
  always_ff @(posedge clk) begin
    if (!reset_n)                   stop_pending <= 1'b0;
    else if (dwell_end && pass_end) stop_pending <= 1'b0;
    else if (stop && busy)          stop_pending <= 1'b1;
  end

`ifdef TUNER_HOP_IRQ_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                   done_irq <= 1'b0;
    else if (dwell_end && pass_end) done_irq <= 1'b1;
    else if (irq_clr)               done_irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_tuner_hop_ctrl.sv
// tb/tb_tuner_hop_ctrl.sv - scoreboard bench for tuner_hop_ctrl
module tb_tuner_hop_ctrl;
  localparam int FSZ    = 31;
  localparam int AW     = 3;
  localparam int DWSZ   = 24;
  localparam int SETTLE = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, stop, loop_en;
  logic [AW-1:0]   last_idx;
  logic            tbl_we;
  logic [AW-1:0]   tbl_addr;
  logic [FSZ-1:0]  tbl_freq;
  logic            tbl_dir;
  logic [DWSZ-1:0] tbl_dwell;
  logic [FSZ-1:0]  lo_freq;
  logic            lo_dir, mute, hop_strobe, busy;
  logic [AW-1:0]   hop_idx;
`ifdef TUNER_HOP_IRQ_EN
  logic            done_irq, irq_clr;
`endif

  always #5 clk = ~clk;

  tuner_hop_ctrl #(.FSZ(FSZ), .AW(AW), .DWSZ(DWSZ), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .loop_en(loop_en),
    .last_idx(last_idx), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_freq(tbl_freq),
    .tbl_dir(tbl_dir), .tbl_dwell(tbl_dwell), .lo_freq(lo_freq), .lo_dir(lo_dir),
    .mute(mute), .hop_strobe(hop_strobe), .hop_idx(hop_idx), .busy(busy)
`ifdef TUNER_HOP_IRQ_EN
    , .done_irq(done_irq), .irq_clr(irq_clr)
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bench-side copy of the table
  logic [FSZ-1:0] m_freq [8];
  logic           m_dir  [8];
  int             m_dw   [8];

  typedef struct {
    int             idx;
    logic [FSZ-1:0] f;
    logic           d;
    int             t;
  } hop_t;

  hop_t hq[$];
  int   endq[$];
  int   t_next, last_s, last_dw;

  task automatic plan_start();
    // start driven now is sampled at edge cyc+1; strobe visible after edge +2
    t_next = cyc + 3;
  endtask

  task automatic push_hop(input int i, input logic [FSZ-1:0] f, input logic d, input int dw);
    hop_t h;
    h.idx = i; h.f = f; h.d = d; h.t = t_next;
    hq.push_back(h);
    last_s  = t_next;
    last_dw = (dw == 0) ? 1 : dw;
    t_next  = t_next + 2 + SETTLE + last_dw;
  endtask

  task automatic push_model(input int i);
    push_hop(i, m_freq[i], m_dir[i], m_dw[i]);
  endtask

  task automatic push_end();
    endq.push_back(last_s + SETTLE + last_dw);
  endtask

  task automatic wr(input int a, input logic [FSZ-1:0] f, input logic d, input int dw);
    tbl_we = 1'b1; tbl_addr = AW'(a); tbl_freq = f; tbl_dir = d; tbl_dwell = DWSZ'(dw);
    m_freq[a] = f; m_dir[a] = d; m_dw[a] = dw;
    @(posedge clk); #1;
    tbl_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (hop_strobe) seen++;
    end
    if (seen < n) check("strobe_timeout", seen, n);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) check("idle_timeout", busy, 0);
    @(posedge clk); #1;
    check("hops_drained", hq.size(), 0);
    check("ends_drained", endq.size(), 0);
  endtask

  // Monitor / scoreboard consumer
  bit   mon_en = 1'b1;
  logic prev_busy, prev_mute;
  int   mcnt = 0;
  hop_t mh;

  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (hop_strobe) begin
        check("mute_at_strobe", mute, 1);
        if (hq.size() == 0) check("unexpected_strobe", 1, 0);
        else begin
          mh = hq.pop_front();
          check("hop_idx", hop_idx, mh.idx);
          check("lo_freq", lo_freq, mh.f);
          check("lo_dir", lo_dir, mh.d);
          check("strobe_cycle", cyc, mh.t);
        end
      end
      if (mute) mcnt++;
      else if (prev_mute === 1'b1) begin
        check("mute_len", mcnt, SETTLE);
        mcnt = 0;
      end
      if (prev_busy === 1'b1 && !busy) begin
        if (endq.size() == 0) check("unexpected_idle", 1, 0);
        else check("idle_cycle", cyc, endq.pop_front());
      end
    end else begin
      mcnt = 0;
    end
    prev_busy = busy;
    prev_mute = mute;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    reset_n = 1'b0; start = 0; stop = 0; loop_en = 0; last_idx = '0;
    tbl_we = 0; tbl_addr = '0; tbl_freq = '0; tbl_dir = 0; tbl_dwell = '0;
`ifdef TUNER_HOP_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mute", mute, 0);
    check("rst_lo_freq", lo_freq, 0);
    check("rst_lo_dir", lo_dir, 0);
    check("rst_strobe", hop_strobe, 0);
    check("rst_hop_idx", hop_idx, 0);
`ifdef TUNER_HOP_IRQ_EN
    check("rst_done_irq", done_irq, 0);
`endif
    @(posedge clk); #1;

    // Single pass
    wr(0, 31'h1000, 1'b0, 10);
    wr(1, 31'h2000, 1'b1, 5);
    last_idx = 3'd1; loop_en = 1'b0;
    plan_start(); push_model(0); push_model(1); push_end();
    pulse_start();
    wait_idle(200);
    repeat (5) @(posedge clk); #1;
    check("hold_lo_freq", lo_freq, 31'h2000);
    check("hold_lo_dir", lo_dir, 1);
    check("hold_mute", mute, 0);

`ifdef TUNER_HOP_IRQ_EN
    check("irq_set", done_irq, 1);
    irq_clr = 1'b1; @(posedge clk); #1; irq_clr = 1'b0;
    check("irq_cleared", done_irq, 0);
    last_idx = 3'd0;
    plan_start(); push_model(0); push_end();
    s = last_s + SETTLE + last_dw;
    pulse_start();
    while (cyc < s - 1) begin @(posedge clk); #1; end
    irq_clr = 1'b1; @(posedge clk); #1; irq_clr = 1'b0;
    check("irq_set_wins", done_irq, 1);
    wait_idle(100);
    check("irq_sticky", done_irq, 1);
    irq_clr = 1'b1; @(posedge clk); #1; irq_clr = 1'b0;
`endif

    // Loop with stop during entry-0 settle
    last_idx = 3'd1; loop_en = 1'b1;
    plan_start(); push_model(0); push_end();
    pulse_start();
    wait_strobes(1, 20);
    @(posedge clk); #1;
    pulse_stop();
    wait_idle(200);
    check("stop_idx", hop_idx, 0);

    // Zero dwell and wrap, start while busy ignored
    wr(0, 31'h1111, 1'b0, 0);
    wr(1, 31'h2222, 1'b1, 3);
    wr(2, 31'h4444, 1'b0, 2);
    last_idx = 3'd2; loop_en = 1'b1;
    plan_start();
    push_model(0); push_model(1); push_model(2); push_model(0); push_model(1); push_end();
    pulse_start();
    wait_strobes(2, 40);
    @(posedge clk); #1;
    pulse_start();
    check("busy_start_idx", hop_idx, 1);
    check("busy_start_busy", busy, 1);
    wait_strobes(3, 60);
    @(posedge clk); #1;
    pulse_stop();
    wait_idle(200);

    // Table write colliding with fetch of entry 1
    wr(0, 31'h1000, 1'b0, 2);
    wr(1, 31'h2000, 1'b1, 2);
    last_idx = 3'd1; loop_en = 1'b1;
    plan_start();
    push_model(0); push_model(1); push_model(0); push_hop(1, 31'h3333, 1'b1, 2); push_end();
    pulse_start();
    wait_strobes(1, 20);
    repeat (6) @(posedge clk); #1;
    wr(1, 31'h3333, 1'b1, 2);
    wait_strobes(2, 40);
    @(posedge clk); #1;
    loop_en = 1'b0;
    wait_idle(200);

    // Reset mid-dwell, table survives
    wr(0, 31'h5A5A, 1'b1, 20);
    last_idx = 3'd0; loop_en = 1'b0;
    plan_start(); push_model(0);
    pulse_start();
    wait_strobes(1, 20);
    repeat (SETTLE + 2) @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    mon_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    hq.delete(); endq.delete();
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_mute", mute, 0);
    check("mid_rst_lo_freq", lo_freq, 0);
    check("mid_rst_hop_idx", hop_idx, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    plan_start(); push_model(0); push_end();
    pulse_start();
    wait_idle(200);
    check("table_intact", lo_freq, 31'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
